// File: rtl/snn_readout_pkg.sv
// Shared constants for the SNN spike readout path.
// State encoding and default widths used by the window classifier.
package snn_readout_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int DEF_N2 = 2;
    localparam int DEF_CW = 8;
    localparam int DEF_WW = 8;
    localparam int DEF_IW = 1;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        HOLD  = ST_HOLD
    } state_t;

endpackage

// File: rtl/spike_window_classifier_if.sv
// Result handshake bundle between the classifier and the readout host.
// The master drives the result, the slave owns result_ready.
interface spike_window_classifier_if
    import snn_readout_pkg::*;
#(
    parameter int N2 = DEF_N2,
    parameter int CW = DEF_CW,
    parameter int IW = DEF_IW
);

    logic              result_valid;
    logic              result_ready;
    logic [N2*CW-1:0]  spike_counts;
    logic [IW-1:0]     winner;
    logic              tie;
    logic              no_spike;

    modport master (
        output result_valid,
        output spike_counts,
        output winner,
        output tie,
        output no_spike,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  spike_counts,
        input  winner,
        input  tie,
        input  no_spike,
        output result_ready
    );

endinterface

// File: rtl/spike_window_classifier_argmax.sv
// Combinational argmax over per-neuron spike counts.
// Lowest index wins on equal counts; tie flags a shared maximum.
module spike_argmax
    import snn_readout_pkg::*;
#(
    parameter int N2 = DEF_N2,
    parameter int CW = DEF_CW,
    parameter int IW = DEF_IW
) (
    input  logic [N2*CW-1:0] counts,
    output logic [IW-1:0]    winner,
    output logic             tie,
    output logic             no_spike
);

    logic [CW-1:0] max_v;
    logic          seen;

    always_comb begin
        max_v  = '0;
        winner = '0;
        tie    = 1'b0;
        seen   = 1'b0;
        // strict compare keeps the lowest index among equals
        for (int i = 0; i < N2; i++) begin
            if (counts[i*CW +: CW] > max_v) begin
                max_v  = counts[i*CW +: CW];
                winner = IW'(i);
            end
        end
        for (int i = 0; i < N2; i++) begin
            if (counts[i*CW +: CW] == max_v) begin
                tie  = tie | seen;
                seen = 1'b1;
            end
        end
        no_spike = (max_v == '0);
    end

endmodule

// File: rtl/spike_window_classifier.sv
// Counts output-layer spikes over a window of enabled time steps and
// presents per-neuron counts plus the winning neuron over a handshake.
module spike_window_classifier
    import snn_readout_pkg::*;
#(
    parameter int N2 = DEF_N2,
    parameter int CW = DEF_CW,
    parameter int WW = DEF_WW,
    parameter int IW = DEF_IW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          start,
    input  logic [WW-1:0] window_len,
    input  logic [N2-1:0] output_spikes,
    output logic          busy,
    spike_window_classifier_if.master res
);

    localparam logic [CW-1:0] SAT = '1;

    state_t           state;
    logic [WW-1:0]    len_q;
    logic [WW-1:0]    step_q;
    logic [N2*CW-1:0] counts_q;
    logic [N2*CW-1:0] counts_nxt;
    logic [IW-1:0]    winner_q;
    logic [IW-1:0]    winner_d;
    logic             tie_q;
    logic             tie_d;
    logic             nospk_q;
    logic             nospk_d;
    logic             valid_q;
    logic             step_en;
    logic             last_step;

    assign step_en   = (state == ACCUM) && enable && (len_q != '0);
    assign last_step = step_en && (step_q == len_q - WW'(1));

    always_comb begin
        counts_nxt = counts_q;
        for (int i = 0; i < N2; i++) begin
            if (step_en && output_spikes[i] &&
                counts_q[i*CW +: CW] != SAT) begin
                counts_nxt[i*CW +: CW] = counts_q[i*CW +: CW] + CW'(1);
            end
        end
    end

    // Decision sees the counts including the final step's spikes
    spike_argmax #(
        .N2 (N2),
        .CW (CW),
        .IW (IW)
    ) u_argmax (
        .counts   (counts_nxt),
        .winner   (winner_d),
        .tie      (tie_d),
        .no_spike (nospk_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            len_q    <= '0;
            step_q   <= '0;
            counts_q <= '0;
            winner_q <= '0;
            tie_q    <= 1'b0;
            nospk_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        counts_q <= '0;
                        len_q    <= window_len;
                        step_q   <= '0;
                        winner_q <= '0;
                        tie_q    <= 1'b0;
                        nospk_q  <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (len_q == '0 || last_step) begin
                        counts_q <= counts_nxt;
                        winner_q <= winner_d;
                        tie_q    <= tie_d;
                        nospk_q  <= nospk_d;
                        valid_q  <= 1'b1;
                        state    <= HOLD;
                    end else if (step_en) begin
                        counts_q <= counts_nxt;
                        step_q   <= step_q + WW'(1);
                    end
                end
                HOLD: begin
                    if (res.result_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state == ACCUM);
    assign res.result_valid = valid_q;
    assign res.spike_counts = counts_q;
    assign res.winner       = winner_q;
    assign res.tie          = tie_q;
    assign res.no_spike     = nospk_q;

endmodule

// File: tb/tb_spike_window_classifier.sv
// Bench for spike_window_classifier: directed scenarios plus random
// windows checked against a counting model of the window rules.
module tb_spike_window_classifier;
    import snn_readout_pkg::*;

    localparam int N2  = 2;
    localparam int CW  = 4;
    localparam int WW  = 8;
    localparam int IW  = 1;
    localparam int SAT = (1 << CW) - 1;

    typedef int cnt_a [N2];
    typedef logic [N2*CW-1:0] cvec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic [N2-1:0] output_spikes = '0;
    logic          busy;

    int n_checks = 0;
    int n_fail = 0;

    spike_window_classifier_if #(.N2(N2), .CW(CW), .IW(IW)) rif ();

    spike_window_classifier #(
        .N2 (N2),
        .CW (CW),
        .WW (WW),
        .IW (IW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .start         (start),
        .window_len    (window_len),
        .output_spikes (output_spikes),
        .busy          (busy),
        .res           (rif.master)
    );

    always #5 clk = ~clk;

    task automatic step(input logic en, input logic [N2-1:0] sp);
        enable = en;
        output_spikes = sp;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        output_spikes = '0;
    endtask

    task automatic start_win(input int len);
        window_len = WW'(len);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one window; early counts cycles where the result showed up too soon
    task automatic drive(input int len, input bit en_q[$],
                         input logic [N2-1:0] sp_q[$], output int early);
        early = 0;
        start_win(len);
        foreach (en_q[k]) begin
            if (rif.result_valid !== 1'b0 || busy !== 1'b1) early++;
            step(en_q[k], sp_q[k]);
        end
    endtask

    task automatic accept();
        rif.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rif.result_ready = 1'b0;
    endtask

    function automatic void model_counts(input bit en_q[$],
                                         input logic [N2-1:0] sp_q[$],
                                         output cnt_a c);
        foreach (c[i]) c[i] = 0;
        foreach (en_q[k])
            if (en_q[k])
                for (int i = 0; i < N2; i++)
                    if (sp_q[k][i]) c[i]++;
        foreach (c[i]) if (c[i] > SAT) c[i] = SAT;
    endfunction

    function automatic void model_decide(input cnt_a c, output int w,
                                         output bit t, output bit ns);
        int m = 0;
        int hits = 0;
        foreach (c[i]) if (c[i] > m) m = c[i];
        w = -1;
        foreach (c[i])
            if (c[i] == m) begin
                hits++;
                if (w < 0) w = i;
            end
        t = (hits > 1);
        ns = (m == 0);
    endfunction

    function automatic cvec_t pack_counts(input cnt_a c);
        cvec_t p = '0;
        foreach (c[i]) p[i*CW +: CW] = CW'(c[i]);
        return p;
    endfunction

    task automatic test_reset();
        #3;
        n_checks++; if (rif.result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rif.result_valid); end
        n_checks++; if (rif.spike_counts !== 8'h00) begin n_fail++; $display("FAIL rst_counts: got %h want 00", rif.spike_counts); end
        n_checks++; if ({rif.winner, rif.tie, rif.no_spike, busy} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {rif.winner, rif.tie, rif.no_spike, busy}); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_win(10);
        for (int k = 0; k < 4; k++) step(1'b1, 2'b11);
        n_checks++; if (busy !== 1'b1 || rif.spike_counts !== 8'h44) begin n_fail++; $display("FAIL mid_accum: got busy=%b counts=%h want busy=1 counts=44", busy, rif.spike_counts); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if ({busy, rif.result_valid, rif.spike_counts, rif.winner, rif.tie, rif.no_spike} !== '0) begin n_fail++; $display("FAIL async_rst: got busy=%b counts=%h want all 0", busy, rif.spike_counts); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_win(2);
        step(1'b1, 2'b01);
        step(1'b1, 2'b01);
        n_checks++; if (rif.result_valid !== 1'b1 || rif.spike_counts !== 8'h02) begin n_fail++; $display("FAIL post_rst_run: got valid=%b counts=%h want valid=1 counts=02", rif.result_valid, rif.spike_counts); end
        accept();
    endtask

    task automatic test_basic();
        int early;
        drive(4, '{1, 1, 1, 1}, '{2'b01, 2'b11, 2'b01, 2'b11}, early);
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL basic_latency: got %0d early cycles want 0", early); end
        n_checks++; if (rif.result_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_valid: got valid=%b busy=%b want 1/0", rif.result_valid, busy); end
        n_checks++; if (rif.spike_counts !== 8'h24) begin n_fail++; $display("FAIL basic_counts: got %h want 24", rif.spike_counts); end
        n_checks++; if ({rif.winner, rif.tie, rif.no_spike} !== 3'b000) begin n_fail++; $display("FAIL basic_decision: got %b want 000", {rif.winner, rif.tie, rif.no_spike}); end
        accept();
        n_checks++; if (rif.result_valid !== 1'b0 || rif.spike_counts !== 8'h24) begin n_fail++; $display("FAIL basic_release: got valid=%b counts=%h want 0/24", rif.result_valid, rif.spike_counts); end
    endtask

    task automatic test_gapped();
        int early;
        drive(3, '{1, 0, 1, 0, 0, 1}, '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10}, early);
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL gap_latency: got %0d early cycles want 0", early); end
        n_checks++; if (rif.result_valid !== 1'b1 || rif.spike_counts !== 8'h30) begin n_fail++; $display("FAIL gap_counts: got valid=%b counts=%h want 1/30", rif.result_valid, rif.spike_counts); end
        n_checks++; if (rif.winner !== 1'b1 || rif.tie !== 1'b0) begin n_fail++; $display("FAIL gap_winner: got w=%b t=%b want 1/0", rif.winner, rif.tie); end
        accept();
    endtask

    task automatic test_tie_empty();
        int early;
        drive(3, '{1, 1, 1}, '{2'b11, 2'b11, 2'b11}, early);
        n_checks++; if (rif.spike_counts !== 8'h33 || {rif.winner, rif.tie, rif.no_spike} !== 3'b010) begin n_fail++; $display("FAIL tie_33: got counts=%h wtn=%b want 33/010", rif.spike_counts, {rif.winner, rif.tie, rif.no_spike}); end
        accept();
        start_win(0);
        n_checks++; if (rif.result_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL len0_first: got valid=%b busy=%b want 0/1", rif.result_valid, busy); end
        step(1'b1, 2'b11);
        n_checks++; if (rif.result_valid !== 1'b1 || rif.spike_counts !== 8'h00 || {rif.winner, rif.tie, rif.no_spike} !== 3'b011) begin n_fail++; $display("FAIL len0_hold: got valid=%b counts=%h wtn=%b want 1/00/011", rif.result_valid, rif.spike_counts, {rif.winner, rif.tie, rif.no_spike}); end
        accept();
        drive(5, '{1, 1, 1, 1, 1}, '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00}, early);
        n_checks++; if (rif.result_valid !== 1'b1 || rif.spike_counts !== 8'h00 || {rif.winner, rif.tie, rif.no_spike} !== 3'b011) begin n_fail++; $display("FAIL empty_run: got valid=%b counts=%h wtn=%b want 1/00/011", rif.result_valid, rif.spike_counts, {rif.winner, rif.tie, rif.no_spike}); end
        accept();
    endtask

    task automatic test_saturation();
        bit en_q[$];
        logic [N2-1:0] sp_q[$];
        int early;
        for (int k = 0; k < 20; k++) begin
            en_q.push_back(1'b1);
            sp_q.push_back({(k % 4 == 0), 1'b1});
        end
        drive(20, en_q, sp_q, early);
        n_checks++; if (early !== 0 || rif.result_valid !== 1'b1) begin n_fail++; $display("FAIL sat_latency: got early=%0d valid=%b want 0/1", early, rif.result_valid); end
        n_checks++; if (rif.spike_counts !== 8'h5F) begin n_fail++; $display("FAIL sat_counts: got %h want 5f", rif.spike_counts); end
        accept();
    endtask

    task automatic test_backpressure();
        int early;
        drive(2, '{1, 1}, '{2'b10, 2'b10}, early);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            window_len = 8'd7;
            step(1'b1, 2'b01);
            n_checks++; if (rif.result_valid !== 1'b1 || busy !== 1'b0 || rif.spike_counts !== 8'h20 || rif.winner !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d: got valid=%b busy=%b counts=%h w=%b want 1/0/20/1", k, rif.result_valid, busy, rif.spike_counts, rif.winner); end
        end
        start = 1'b0;
        accept();
        n_checks++; if (rif.result_valid !== 1'b0 || busy !== 1'b0 || rif.spike_counts !== 8'h20 || rif.winner !== 1'b1) begin n_fail++; $display("FAIL bp_release: got valid=%b busy=%b counts=%h w=%b want 0/0/20/1", rif.result_valid, busy, rif.spike_counts, rif.winner); end
        accept();
        n_checks++; if (rif.result_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_ready: got valid=%b busy=%b want 0/0", rif.result_valid, busy); end
        drive(1, '{1}, '{2'b01}, early);
        n_checks++; if (rif.result_valid !== 1'b1 || rif.spike_counts !== 8'h01 || rif.winner !== 1'b0) begin n_fail++; $display("FAIL bp_restart: got valid=%b counts=%h w=%b want 1/01/0", rif.result_valid, rif.spike_counts, rif.winner); end
        accept();
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            bit en_q[$];
            logic [N2-1:0] sp_q[$];
            cnt_a c;
            int len, got, early, w, waits;
            bit t, ns;
            len = $urandom_range(1, 24);
            got = 0;
            while (got < len) begin
                bit e;
                e = ($urandom_range(0, 99) < 70);
                if (got == len - 1 && !e && $urandom_range(0, 1) == 1) e = 1'b1;
                en_q.push_back(e);
                sp_q.push_back(N2'($urandom));
                if (e) got++;
            end
            model_counts(en_q, sp_q, c);
            model_decide(c, w, t, ns);
            drive(len, en_q, sp_q, early);
            n_checks++; if (early !== 0 || rif.result_valid !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_latency: got early=%0d valid=%b want 0/1", r, early, rif.result_valid); end
            n_checks++; if (rif.spike_counts !== pack_counts(c)) begin n_fail++; $display("FAIL rnd%0d_counts: got %h want %h", r, rif.spike_counts, pack_counts(c)); end
            n_checks++; if (rif.winner !== IW'(w) || rif.tie !== t || rif.no_spike !== ns) begin n_fail++; $display("FAIL rnd%0d_decision: got w=%b t=%b ns=%b want %0d/%b/%b", r, rif.winner, rif.tie, rif.no_spike, w, t, ns); end
            waits = $urandom_range(0, 3);
            for (int k = 0; k < waits; k++) step(1'b1, N2'($urandom));
            n_checks++; if (rif.result_valid !== 1'b1 || rif.spike_counts !== pack_counts(c)) begin n_fail++; $display("FAIL rnd%0d_stable: got valid=%b counts=%h want 1/%h", r, rif.result_valid, rif.spike_counts, pack_counts(c)); end
            accept();
            n_checks++; if (rif.result_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_release: got valid=%b want 0", r, rif.result_valid); end
        end
    endtask

    initial begin
        rif.result_ready = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_tie_empty();
        test_saturation();
        test_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_window_classifier.md
Name: spike_window_classifier

Overview:
- Sits directly downstream of the two-layer SNN and consumes its second-layer output_spikes.
- Counts output spikes per output neuron over a programmable window of network time steps (cycles with enable high), then picks the winning neuron.
- Presents the counts and the decision to the host/readout logic through a valid/ready handshake.
- Turns the raw spike trains into a classification result for the debug/readout path.

Parameters:
- N2, 2, number of output neurons observed (matches network output width).
- CW, 8, per-neuron spike counter width in bits; counters saturate at 2^CW-1.
- WW, 8, width of the window-length (time-step) counter.
- IW, 1, width of the winner index (must be at least ceil(log2(N2)), minimum 1).

Ports:
- clk  in  1  system clock; the network runs on the same clock.
- reset_n  in  1  asynchronous reset, active-low.
- enable  in  1  network time-step strobe; same signal that enables the network; one step per cycle it is high.
- start  in  1  pulse: begin a new window; honoured only in IDLE.
- window_len  in  WW  number of time steps per window; sampled when start is accepted.
- output_spikes  in  N2  spike vector from the network's second layer.
- busy  out  1  high while in ACCUM.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- spike_counts  out  N2*CW  per-neuron counts; neuron i at bits [i*CW +: CW].
- winner  out  IW  index of the neuron with the maximum count.
- tie  out  1  more than one neuron shares the maximum count.
- no_spike  out  1  maximum count is zero.

Behaviour:
- States: IDLE, ACCUM, HOLD.
- Reset (reset_n low, asynchronous) returns to IDLE with all outputs and internal registers at 0: busy, result_valid, spike_counts, winner, tie, no_spike.
- IDLE + start:
  - Clear the counts, latch window_len into len_q, clear the step counter, go to ACCUM.
  - If window_len == 0, skip to HOLD on the next edge: counts stay 0, no_spike=1, tie=1 when N2>1, winner=0.
- ACCUM, cycle with enable=1:
  - For each i, if output_spikes[i] then count[i] increments, saturating at 2^CW-1.
  - The step counter increments.
  - When the step counter reaches len_q-1 on an enable cycle, that step's spikes are included and the next state is HOLD.
- ACCUM, cycle with enable=0: counts and step counter hold; spikes are ignored (not a valid time step).
- start asserted in ACCUM or HOLD is ignored.
- Decision logic, registered on entry to HOLD:
  - winner = lowest index with the maximum count.
  - tie = 1 when two or more indices share the maximum.
  - no_spike = 1 when the maximum is 0.
  - result_valid rises in the first HOLD cycle, so the latency from the last counted enable step to result_valid is 1 cycle.
- HOLD: result_valid=1 and all result outputs stable until result_ready=1.
  - The handshake completes on the edge where result_valid and result_ready are both 1.
  - Then go to IDLE, with result_valid=0 from the next cycle.
  - spike_counts, winner, tie and no_spike keep their values in IDLE until the next accepted start.
- result_ready while not valid: no effect.
- Counter widths: the step counter is WW bits and compares against len_q, so the maximum window is 2^WW-1 steps.
- Comparisons are unsigned, CW bits.
- busy = (state == ACCUM).

Decomposition:
- Shared package snn_readout_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_HOLD=2'd2;
  - default CW/WW constants.
- One sub-module: spike_argmax (combinational, parameterised N2/CW/IW), producing winner, tie and no_spike from the count vector.
  - Its outputs are registered by the parent FSM on entry to HOLD.

Test Plan:
- Reset mid-ACCUM: start with window_len=10, pull reset_n low after 4 steps -> all outputs 0 immediately (asynchronously), state IDLE, and a new start works normally.
- Basic window: N2=2, window_len=4, enable always 1, spikes n0=1111 and n1=0101 -> result_valid one cycle after the 4th step; counts {n1=2, n0=4}; winner=0; tie=0; no_spike=0.
- Gapped enable: window_len=3, enable pattern 1,0,1,0,0,1 with n1 spiking on every cycle (including the disabled ones) -> count n1=3, not 6; result_valid one cycle after the 6th cycle.
- Tie and empty:
  - equal counts 3/3 -> winner=0, tie=1;
  - a separate run with no spikes -> counts 0/0, no_spike=1, tie=1;
  - window_len=0 -> HOLD next cycle with no_spike=1.
- Saturation: CW=4, window_len=20, n0 spiking every step -> count n0=15, no wrap to 4.
- Backpressure: hold result_ready=0 for 5 cycles with start pulsed during HOLD -> outputs stable and start ignored; result_ready=1 -> result_valid falls the next cycle, and a new start is then accepted.
